// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// sram_arb_pkg: shared types and default timing for the SRAM arbiter.  Rev 1.0
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    REC   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam int C_ADDR_W     = 20;
  localparam int C_DATA_W     = 32;
  localparam int C_RD_CYCLES  = 2;
  localparam int C_WR_CYCLES  = 2;
  localparam int C_REC_CYCLES = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// sram_arbiter_if: fetch/data request ports plus the SRAM-side bundle.  Rev 1.0
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_we;
  logic [DATA_W-1:0] i_req_wdata;
  logic [MASK_W-1:0] i_req_wmask;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_rdata;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic [DATA_W-1:0] d_req_wdata;
  logic [MASK_W-1:0] d_req_wmask;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_rdata;

  logic [DATA_W-1:0] io_sram_dout;
  logic [ADDR_W-1:0] io_sram_addr;
  logic [DATA_W-1:0] io_sram_din;
  logic              io_sram_en;
  logic              io_sram_re;
  logic              io_sram_we;
  logic [MASK_W-1:0] io_sram_wmask;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_wmask,
    output i_req_ready, i_resp_valid, i_resp_rdata,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wmask,
    output d_req_ready, d_resp_valid, d_resp_rdata,
    input  io_sram_dout,
    output io_sram_addr, io_sram_din, io_sram_en, io_sram_re, io_sram_we, io_sram_wmask
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_wmask,
    input  i_req_ready, i_resp_valid, i_resp_rdata,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wmask,
    input  d_req_ready, d_resp_valid, d_resp_rdata,
    output io_sram_dout,
    input  io_sram_addr, io_sram_din, io_sram_en, io_sram_re, io_sram_we, io_sram_wmask
  );

endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// sram_arbiter: shares one async-SRAM port between fetch and data requesters,
// data has fixed priority; all SRAM controls are registered.  Rev 1.0
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = C_ADDR_W,
  parameter int DATA_W     = C_DATA_W,
  parameter int RD_CYCLES  = C_RD_CYCLES,
  parameter int WR_CYCLES  = C_WR_CYCLES,
  parameter int REC_CYCLES = C_REC_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arbiter_if.slave  bus
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(max3(RD_CYCLES, WR_CYCLES, REC_CYCLES) + 1);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = (REC_CYCLES > 0) ? CNT_W'(REC_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            r_state, w_next;
  port_t             r_owner;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_en, r_re, r_we;
  logic [MASK_W-1:0] r_wmask;
  logic              r_i_resp_valid, r_d_resp_valid;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;

  logic              w_i_acc, w_d_acc, w_acc, w_done;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_we;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [MASK_W-1:0] w_sel_wmask;

  // Data wins: fetch is only offered the port when no data request is pending.
  assign bus.d_req_ready = (r_state == IDLE);
  assign bus.i_req_ready = (r_state == IDLE) && !bus.d_req_valid;

  assign w_d_acc = bus.d_req_valid && bus.d_req_ready;
  assign w_i_acc = bus.i_req_valid && bus.i_req_ready;
  assign w_acc   = w_d_acc || w_i_acc;

  assign w_sel_addr  = w_d_acc ? bus.d_req_addr  : bus.i_req_addr;
  assign w_sel_we    = w_d_acc ? bus.d_req_we    : bus.i_req_we;
  assign w_sel_wdata = w_d_acc ? bus.d_req_wdata : bus.i_req_wdata;
  assign w_sel_wmask = w_d_acc ? bus.d_req_wmask : bus.i_req_wmask;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_next     = w_sel_we ? WRITE : READ;
          w_cnt_next = w_sel_we ? WR_LOAD : RD_LOAD;
        end
      end
      READ: begin
        if (r_cnt == '0) w_next = IDLE;
        else             w_cnt_next = r_cnt - CNT_ONE;
      end
      WRITE: begin
        if (r_cnt == '0) begin
          if (REC_CYCLES > 0) begin
            w_next     = REC;
            w_cnt_next = REC_LOAD;
          end else begin
            w_next = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      REC: begin
        if (r_cnt == '0) w_next = IDLE;
        else             w_cnt_next = r_cnt - CNT_ONE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_done = (r_state != IDLE) && (w_next == IDLE);

  // SRAM controls are decoded from the next state so they are registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_owner        <= PORT_I;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_din          <= '0;
      r_en           <= 1'b0;
      r_re           <= 1'b0;
      r_we           <= 1'b0;
      r_wmask        <= '0;
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_acc) begin
        r_owner <= w_d_acc ? PORT_D : PORT_I;
        r_addr  <= w_sel_addr;
        r_din   <= w_sel_wdata;
      end
      r_en <= (w_next != IDLE);
      r_re <= (w_next == READ);
      r_we <= (w_next == WRITE);
      case (w_next)
        READ:    r_wmask <= '1;
        WRITE:   r_wmask <= w_acc ? w_sel_wmask : r_wmask;
        default: r_wmask <= '0;
      endcase
      r_i_resp_valid <= w_done && (r_owner == PORT_I);
      r_d_resp_valid <= w_done && (r_owner == PORT_D);
      if (w_done && (r_state == READ)) begin
        if (r_owner == PORT_D) r_d_rdata <= bus.io_sram_dout;
        else                   r_i_rdata <= bus.io_sram_dout;
      end
    end
  end

  assign bus.io_sram_addr  = r_addr;
  assign bus.io_sram_din   = r_din;
  assign bus.io_sram_en    = r_en;
  assign bus.io_sram_re    = r_re;
  assign bus.io_sram_we    = r_we;
  assign bus.io_sram_wmask = r_wmask;
  assign bus.i_resp_valid  = r_i_resp_valid;
  assign bus.d_resp_valid  = r_d_resp_valid;
  assign bus.i_resp_rdata  = r_i_rdata;
  assign bus.d_resp_rdata  = r_d_rdata;

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one SRAM port (the `io_sram_*` bundle consumed by `ram_wrapper`) between an instruction-fetch requester and a data requester. This lets the core load and store data in base RAM as well as fetch instructions from it. The block sits directly upstream of `ram_wrapper`. It sequences multi-cycle asynchronous-SRAM read and write accesses with registered control outputs and returns one response pulse per accepted request.

## Interface
- `ADDR_W`, 20, SRAM word-address width
- `DATA_W`, 32, data width; mask width is `DATA_W/8`
- `RD_CYCLES`, 2, cycles `en`/`re` are held per read (≥1)
- `WR_CYCLES`, 2, cycles `we` is held per write (≥1)
- `REC_CYCLES`, 1, write-recovery cycles: `en`=1, `we`=0, addr/data held (≥0)

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `i_req_valid`/`d_req_valid` in 1: request present on port i / d
- `i_req_ready`/`d_req_ready` out 1: request accepted this cycle when valid&ready
- `i_req_addr`/`d_req_addr` in ADDR_W: word address
- `i_req_we`/`d_req_we` in 1: 1 = write, 0 = read
- `i_req_wdata`/`d_req_wdata` in DATA_W: write data
- `i_req_wmask`/`d_req_wmask` in DATA_W/8: byte-enable, active-high
- `i_resp_valid`/`d_resp_valid` out 1: one-cycle completion pulse, for reads and writes
- `i_resp_rdata`/`d_resp_rdata` out DATA_W: read data; valid with `resp_valid` on reads
- `io_sram_dout` in DATA_W: read data from `ram_wrapper`
- `io_sram_addr` out ADDR_W; `io_sram_din` out DATA_W; `io_sram_en`, `io_sram_re`, `io_sram_we` out 1; `io_sram_wmask` out DATA_W/8

## Operation
- FSM states: IDLE, READ, WRITE, REC.
- IDLE:
  - `d_req_ready` = 1.
  - `i_req_ready` = !`d_req_valid`.
  - Fixed priority: data wins over fetch.
  - Ready signals are combinational from state and `d_req_valid`; they are 0 in every other state.
- Accept:
  - Latch addr, wdata, wmask, we and the port id.
  - Go to READ or WRITE and load the counter with `RD_CYCLES-1` or `WR_CYCLES-1`.
- READ:
  - Drive `en`=1, `re`=1, `we`=0, `wmask`=all-ones.
  - When the counter reaches 0, register `io_sram_dout` into the owner's `rdata` and go to IDLE.
- WRITE:
  - Drive `en`=1, `we`=1, `re`=0, `din`/`wmask` = latched values.
  - When the counter reaches 0, go to REC if `REC_CYCLES`>0, otherwise go to IDLE.
- REC:
  - Drive `en`=1, `we`=0, `re`=0; addr and din are held.
  - Count `REC_CYCLES`, then go to IDLE.
- Response:
  - The owner's `resp_valid` pulses for exactly one cycle, the first cycle back in IDLE.
  - A new request can be accepted in that same cycle.
- `rdata` holds its value until the next read completes on that port.
- Write `rdata` is unchanged.
- A write with wmask=0 executes the full write timing and is acknowledged.
- No starvation avoidance: continuous `d_req_valid` blocks fetch indefinitely. This is by design, since the data stage stalls the pipeline.
- Protocol rules for requesters:
  - Hold request fields stable while valid & !ready.
  - At most one outstanding request per port.

## Timing
- All `io_sram_*` outputs are registered.
- Reset and IDLE values:
  - `en`=`re`=`we`=0, `wmask`=0.
  - `addr`/`din` = 0 at reset, hold their last value in IDLE.
  - `resp_valid`=0, `rdata`=0.
- Accept in cycle T:
  - Read: SRAM driven T+1..T+RD_CYCLES; `dout` sampled at the end of T+RD_CYCLES; `resp_valid` at T+RD_CYCLES+1.
  - Write: `we` T+1..T+WR_CYCLES; REC through T+WR_CYCLES+REC_CYCLES; `resp_valid` at T+WR_CYCLES+REC_CYCLES+1.
- Throughput with defaults: one read per 3 cycles, one write per 4 cycles.
- The counter is sized to `$clog2(max(RD_CYCLES, WR_CYCLES, REC_CYCLES)+1)`.
- Asynchronous reset mid-access:
  - All outputs go immediately to reset values and the FSM goes to IDLE.
  - The in-flight request is dropped with no response, including after `rst_n` releases.

## Structure
- Package `sram_arb_pkg`: state enum (IDLE/READ/WRITE/REC), port-id enum (PORT_I/PORT_D), and default cycle constants.
- No sub-module. Port mux, FSM, counter and response registers live in one module.

## Test plan
- Fetch read addr 0x00010, `dout`=0xDEADBEEF, defaults:
  - `en`/`re` high exactly T+1..T+2.
  - `i_resp_valid` pulse at T+3 with `i_resp_rdata`=0xDEADBEEF.
  - `d_resp_valid` stays 0.
- Simultaneous i and d reads (i 0x00100, d 0x00200):
  - d granted first; `i_req_ready`=0 until d responds.
  - i accepted in the same cycle as `d_resp_valid`.
- Data write addr 0x12345, wdata 0xA5A5A5A5, wmask 0b0011:
  - `we`=1 and `wmask`=0b0011 for 2 cycles.
  - Then 1 cycle of `en`=1, `we`=0 with addr/din held.
  - `d_resp_valid` at T+4.
- 8 back-to-back fetch reads, valid held high:
  - Accepts every 3 cycles.
  - Responses in order, each carrying the `dout` presented during its access.
- `rst_n` low at T+1 of a read:
  - Outputs zero in the same cycle.
  - No `resp_valid` for 10 cycles after release.
  - The next request completes normally.
- Write 0xCAFEF00D then read the same address (SRAM model) -> read returns 0xCAFEF00D, with read `en` starting one cycle after the write's `resp_valid`.
